// File: rtl/cluster_packer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cluster_packer_seq
//  Purpose  : Sequential S-bit cluster finder. Latches one frame, then
//             extracts clusters lowest address first, one per clock, and
//             publishes a registered list of {cnt, adr} words + overflow.
//  Revision : 1.0  initial release
// ============================================================================
module cluster_packer_seq #(
  parameter int NUM_VFATS      = 24,
  parameter int SBITS_PER_VFAT = 64,
  parameter int NUM_CLUSTERS   = 8,
  parameter int CNT_BITS       = 3,
  parameter int ADR_BITS       = 11
) (
  input  logic                                           clock4x,
  input  logic                                           global_reset_n,
  input  logic [NUM_VFATS*SBITS_PER_VFAT-1:0]            sbits,
  input  logic                                           sbits_valid,
  output logic                                           sbits_ready,
  input  logic                                           truncate_clusters,
  output logic [NUM_CLUSTERS*(CNT_BITS+ADR_BITS)-1:0]    clusters,
  output logic                                           clusters_valid,
  output logic [$clog2(NUM_CLUSTERS+1)-1:0]              num_found,
  output logic                                           overflow
);

  localparam int c_total    = NUM_VFATS * SBITS_PER_VFAT;
  localparam int c_w        = CNT_BITS + ADR_BITS;
  localparam int c_max_size = 1 << CNT_BITS;
  localparam int c_nf_bits  = $clog2(NUM_CLUSTERS + 1);

  localparam logic [c_w-1:0]       c_invalid  = {{CNT_BITS{1'b0}}, {ADR_BITS{1'b1}}};
  localparam logic [CNT_BITS:0]    c_len_one  = (CNT_BITS+1)'(1);
  localparam logic [CNT_BITS:0]    c_max_len  = (CNT_BITS+1)'(c_max_size);
  localparam logic [c_nf_bits-1:0] c_nf_one   = c_nf_bits'(1);
  localparam logic [c_nf_bits-1:0] c_nf_full  = c_nf_bits'(NUM_CLUSTERS);

  // The all-ones address is reserved as the invalid-slot marker.
  generate
    if (c_total >= (1 << ADR_BITS) - 1) begin : g_bad_params
      $error("cluster_packer_seq: ADR_BITS too small for NUM_VFATS*SBITS_PER_VFAT");
    end
  endgenerate

  // Marks every strip whose position within its VFAT equals pos.
  function automatic logic [c_total-1:0] f_vfat_pos(input int pos);
    logic [c_total-1:0] v;
    v = '0;
    for (int i = 0; i < c_total; i++) begin
      if ((i % SBITS_PER_VFAT) == pos) v[i] = 1'b1;
    end
    return v;
  endfunction

  localparam logic [c_total-1:0] c_first = f_vfat_pos(0);
  localparam logic [c_total-1:0] c_last  = f_vfat_pos(SBITS_PER_VFAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SEARCH = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                               r_state;
  state_t                               w_state_next;
  logic                                 w_ready;

  logic [c_total-1:0]                   r_hits;
  logic                                 r_trunc;
  logic [c_total-1:0]                   r_mask;
  logic [c_nf_bits-1:0]                 r_count;
  logic [NUM_CLUSTERS-1:0][c_w-1:0]     r_work;

  logic [NUM_CLUSTERS-1:0][c_w-1:0]     r_clusters;
  logic [c_nf_bits-1:0]                 r_num_found;
  logic                                 r_overflow;
  logic                                 r_valid;

  logic [c_total-1:0]                   w_start_init;
  logic [ADR_BITS-1:0]                  w_s;
  logic                                 w_found;
  logic [CNT_BITS:0]                    w_len;
  logic                                 w_alive;
  logic                                 w_cont;
  logic [CNT_BITS-1:0]                  w_cnt;
  logic [c_total-1:0]                   w_mask_next;
  logic [NUM_CLUSTERS-1:0][c_w-1:0]     w_work_next;
  logic [c_nf_bits-1:0]                 w_count_inc;
  logic                                 w_count_full;

  // A strip starts a cluster if hit and not continuing a run inside its VFAT.
  assign w_start_init = r_hits & (c_first | ~{r_hits[c_total-2:0], 1'b0});

  assign w_cnt        = CNT_BITS'(w_len - c_len_one);
  assign w_count_inc  = r_count + c_nf_one;
  assign w_count_full = w_found && (w_count_inc == c_nf_full);

  // Lowest pending start address.
  always_comb begin
    w_s     = '0;
    w_found = 1'b0;
    for (int i = c_total - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_s     = ADR_BITS'(i);
        w_found = 1'b1;
      end
    end
  end

  // Run length from w_s, capped at the max size and at the VFAT edge.
  always_comb begin
    w_len   = c_len_one;
    w_alive = 1'b1;
    for (int j = 1; j < c_max_size; j++) begin
      if (w_alive && (int'(w_s) + j < c_total) &&
          !c_last[int'(w_s) + j - 1] && r_hits[int'(w_s) + j]) begin
        w_len = w_len + c_len_one;
      end else begin
        w_alive = 1'b0;
      end
    end
    w_cont = (w_len == c_max_len) && (int'(w_s) + c_max_size < c_total) &&
             !c_last[int'(w_s) + c_max_size - 1] && r_hits[int'(w_s) + c_max_size];
  end

  // Retire the current start; a long run re-seeds a start MAX_SIZE above it.
  always_comb begin
    w_mask_next = r_mask;
    if (w_found) begin
      w_mask_next[w_s] = 1'b0;
      if (w_cont && !r_trunc) w_mask_next[int'(w_s) + c_max_size] = 1'b1;
    end
  end

  // Write the found cluster into the slot selected by the counter.
  always_comb begin
    w_work_next = r_work;
    for (int k = 0; k < NUM_CLUSTERS; k++) begin
      if (w_found && (r_count == c_nf_bits'(k))) w_work_next[k] = {w_cnt, w_s};
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (sbits_valid) w_state_next = ST_LOAD;
      end
      ST_LOAD:   w_state_next = ST_SEARCH;
      ST_SEARCH: if (!w_found || w_count_full) w_state_next = ST_DONE;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) r_state <= ST_IDLE;
    else                 r_state <= w_state_next;
  end

  // Frame capture, search datapath and published result registers.
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      r_hits      <= '0;
      r_trunc     <= 1'b0;
      r_mask      <= '0;
      r_count     <= '0;
      r_work      <= {NUM_CLUSTERS{c_invalid}};
      r_clusters  <= {NUM_CLUSTERS{c_invalid}};
      r_num_found <= '0;
      r_overflow  <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sbits_valid) begin
            r_hits  <= sbits;
            r_trunc <= truncate_clusters;
          end
        end
        ST_LOAD: begin
          r_mask  <= w_start_init;
          r_count <= '0;
          r_work  <= {NUM_CLUSTERS{c_invalid}};
        end
        ST_SEARCH: begin
          r_mask <= w_mask_next;
          r_work <= w_work_next;
          if (w_found) r_count <= w_count_inc;
          // Publish on entry to DONE so the list is visible with the pulse.
          if (w_state_next == ST_DONE) begin
            r_clusters  <= w_work_next;
            r_num_found <= w_found ? w_count_inc : r_count;
            r_overflow  <= |w_mask_next;
            r_valid     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sbits_ready    = w_ready;
  assign clusters       = r_clusters;
  assign clusters_valid = r_valid;
  assign num_found      = r_num_found;
  assign overflow       = r_overflow;

endmodule
`default_nettype wire
